// File: rtl/gcd_result_display.sv
`default_nettype none
// ============================================================================
// Module   : gcd_result_display
// Purpose  : Converts the GCD result to BCD one bit per cycle (shift-add-3)
//            and scans it onto the 8-digit seven-segment display.
//            Define GCD_DISP_HEX_EN to also show the result as hex on AN[5:4].
// Revision : 1.0  initial release
// ============================================================================
module gcd_result_display #(
   parameter int SCAN_DIV      = 100000,
   parameter int BLANK_LEADING = 1
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic [7:0] RESULT,
   input  logic       RESULT_VALID,
   output logic       BUSY,
   output logic [7:0] CA,
   output logic [7:0] AN
);

   localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
`ifdef GCD_DISP_HEX_EN
   localparam int c_NSLOTS = 5;
`else
   localparam int c_NSLOTS = 3;
`endif

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t               r_state;
   logic [7:0]           r_shift;
   logic [11:0]          r_bcd;
   logic [2:0]           r_iter;
   logic [3:0]           r_hund;
   logic [3:0]           r_tens;
   logic [3:0]           r_ones;
   logic [c_CNT_W-1:0]   r_scan_cnt;
   logic [2:0]           r_slot;
   logic [11:0]          w_bcd_adj;
   logic [11:0]          w_bcd_next;
   logic                 w_blank_hund;
   logic                 w_blank_tens;
   logic [7:0]           w_an;
   logic [7:0]           w_ca;
`ifdef GCD_DISP_HEX_EN
   logic [7:0]           r_hex_cap;
   logic [7:0]           r_hex;
`endif

   function automatic logic [7:0] f_seg(input logic [3:0] d);
      case (d)
         4'h0: f_seg = 8'h03;  4'h1: f_seg = 8'h9F;
         4'h2: f_seg = 8'h25;  4'h3: f_seg = 8'h0D;
         4'h4: f_seg = 8'h99;  4'h5: f_seg = 8'h49;
         4'h6: f_seg = 8'h41;  4'h7: f_seg = 8'h1F;
         4'h8: f_seg = 8'h01;  4'h9: f_seg = 8'h09;
         4'hA: f_seg = 8'h11;  4'hB: f_seg = 8'hC1;
         4'hC: f_seg = 8'h63;  4'hD: f_seg = 8'h85;
         4'hE: f_seg = 8'h61;  default: f_seg = 8'h71;
      endcase
   endfunction

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 3; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
      w_bcd_next = {w_bcd_adj[10:0], r_shift[7]};
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bcd   <= '0;
         r_iter  <= '0;
         r_hund  <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
         BUSY    <= 1'b0;
`ifdef GCD_DISP_HEX_EN
         r_hex_cap <= '0;
         r_hex     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (RESULT_VALID) begin
                  r_shift <= RESULT;
                  r_bcd   <= '0;
                  r_iter  <= '0;
                  r_state <= CONV;
                  BUSY    <= 1'b1;
`ifdef GCD_DISP_HEX_EN
                  r_hex_cap <= RESULT;
`endif
               end
            end
            CONV: begin
               r_bcd   <= w_bcd_next;
               r_shift <= {r_shift[6:0], 1'b0};
               r_iter  <= r_iter + 3'd1;
               // Display digits load only from the completed accumulator
               if (r_iter == 3'd7) begin
                  r_hund  <= w_bcd_next[11:8];
                  r_tens  <= w_bcd_next[7:4];
                  r_ones  <= w_bcd_next[3:0];
                  r_state <= IDLE;
                  BUSY    <= 1'b0;
`ifdef GCD_DISP_HEX_EN
                  r_hex   <= r_hex_cap;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_blank_hund = (BLANK_LEADING != 0) && (r_hund == 4'd0);
   assign w_blank_tens = w_blank_hund && (r_tens == 4'd0);

   always_comb begin
      w_an = 8'hFF;
      w_ca = 8'hFF;
      case (r_slot)
         3'd0: begin w_an[0] = 1'b0; w_ca = f_seg(r_ones); end
         3'd1: begin w_an[1] = 1'b0; w_ca = w_blank_tens ? 8'hFF : f_seg(r_tens); end
         3'd2: begin w_an[2] = 1'b0; w_ca = w_blank_hund ? 8'hFF : f_seg(r_hund); end
`ifdef GCD_DISP_HEX_EN
         3'd3: begin w_an[4] = 1'b0; w_ca = f_seg(r_hex[3:0]); end
         3'd4: begin w_an[5] = 1'b0; w_ca = f_seg(r_hex[7:4]); end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_scan_cnt <= '0;
         r_slot     <= '0;
         AN         <= 8'hFF;
         CA         <= 8'hFF;
      end else begin
         if (r_scan_cnt == c_CNT_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_slot     <= (r_slot == 3'(c_NSLOTS - 1)) ? 3'd0 : r_slot + 3'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + c_CNT_W'(1);
         end
         AN <= w_an;
         CA <= w_ca;
      end
   end

endmodule
`default_nettype wire
